jericalla_fetch_unit: RTL and testbench
=======================================

// Module: jericalla_fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the Jericalla datapath.
//  - Holds a loadable instruction memory and a program counter.
//  - Prefetches 17-bit instruction words ({opcode[16:15], wr[14:10], rdA[9:5], rdB[4:0]}) into a small FIFO.
//  - Presents them to the datapath with a valid/ready handshake, so the core can stall without losing words.
// PARAMETERS
//  INSTR_WIDTH  17  instruction word width
//  IMEM_DEPTH   32  instruction memory words; ADDR_WIDTH = $clog2(IMEM_DEPTH)
//  FIFO_DEPTH   4   prefetch FIFO entries (power of 2, >=2)
// PORTS
//  clock        in   1            single clock, rising edge
//  reset_n      in   1            asynchronous, active-low reset
//  load_we      in   1            write one instruction memory word
//  load_addr    in   ADDR_WIDTH   write address
//  load_data    in   INSTR_WIDTH  write data
//  start        in   1            1-cycle pulse: begin fetching at start_addr
//  start_addr   in   ADDR_WIDTH   first PC value
//  last_addr    in   ADDR_WIDTH   last PC value of the program
//  flush        in   1            1-cycle pulse: discard FIFO and in-flight read, return to IDLE
//  instr_out    out  INSTR_WIDTH  FIFO head instruction
//  instr_valid  out  1            instr_out holds a valid word
//  instr_ready  in   1            consumer accepts; transfer when valid && ready
//  pc_out       out  ADDR_WIDTH   PC of the next memory read
//  busy         out  1            state is FETCH or DRAIN
//  done         out  1            state is DONE
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - state=IDLE, pc_out=0, FIFO empty, in-flight=0.
//    - instr_valid=0, instr_out=0, busy=0, done=0.
//    - Memory contents are not reset.
//  - Memory: synchronous read, 1-cycle latency. The read word is written into the FIFO on the following cycle.
//  - Issue rule: a read is issued only when count + inflight < FIFO_DEPTH, so the FIFO never overflows.
//  - FSM:
//    - IDLE: start -> FETCH, pc<=start_addr.
//    - FETCH: issue reads, pc++. After issuing the read at last_addr -> DRAIN.
//    - DRAIN: no new reads. -> DONE once the in-flight read has landed and the FIFO is empty.
//    - DONE: start -> FETCH, as from IDLE.
//  - start outside IDLE/DONE is ignored.
//  - start_addr > last_addr: fetch exactly one word (start_addr), then DRAIN.
//  - load_we is honoured only in IDLE/DONE. It is ignored in FETCH/DRAIN, and memory is unchanged.
//  - instr_out/instr_valid stay stable while valid && !ready.
//  - Simultaneous push and pop: count unchanged, both happen in the same cycle.
//  - A full FIFO with ready=0 stalls issue; pc holds.
//  - flush has priority over start and handshakes in the same cycle:
//    - FIFO cleared, in-flight data dropped.
//    - state=IDLE, instr_valid=0 the next cycle.
//  - Throughput: 1 instruction/cycle in steady state with ready held high.
//  - First valid appears 2 cycles after the start pulse (read cycle + FIFO write cycle).
// CONFIGURATION
//  JERICALLA_FETCH_LOOP_EN
//    - Defined: after issuing the read at last_addr, pc wraps to start_addr (latched at start) and FETCH continues.
//      DRAIN/DONE are reached only via flush or reset (flush -> IDLE).
//    - Undefined: one pass, behaviour as above.
// STRUCTURE
//  - Shared package jericalla_pkg:
//    - INSTR_WIDTH, opcode enum (OP_ADD=2'b00, OP_SUB=2'b01, OP_TERN=2'b10, OP_SW=2'b11).
//    - Field-slice constants for opcode/wr/rdA/rdB.
//    - fetch_state_t {IDLE, FETCH, DRAIN, DONE}.
//  - One sub-module, jericalla_fetch_fifo: parameterised sync FIFO with count, full and empty outputs.
//  - Memory, PC and FSM live in the top module.
// TESTING
//  1. Load addr0..3 = 17'h00001, 17'h08422, 17'h10C43, 17'h18E4; start_addr=0, last_addr=3, ready=1.
//     -> four words in order on consecutive cycles, first valid 2 cycles after start; done=1 after the last transfer.
//  2. Same program, ready=0 for 10 cycles after start.
//     -> FIFO fills to 4, pc stops at 4, instr_out held at 17'h00001.
//     -> On ready=1 all 4 words are delivered with no loss or duplicate.
//  3. Toggle ready every cycle during FETCH.
//     -> every word is transferred exactly once; instr_out never changes while valid && !ready.
//  4. flush mid-FETCH, with 2 words in the FIFO and 1 in flight.
//     -> next cycle instr_valid=0, state IDLE.
//     -> A later start at addr 2 delivers word 2 first.
//  5. Assert reset_n=0 asynchronously mid-DRAIN.
//     -> all outputs are at reset values before the next clock edge.
//     -> After release, start replays the program correctly (memory retained).
//  6. With JERICALLA_FETCH_LOOP_EN, last_addr=1, ready=1.
//     -> sequence w0,w1,w0,w1... continues; done stays 0.
//     -> Without the macro: w0,w1, then done=1.

Source files
------------

// File: rtl/jericalla_pkg.sv
// Shared Jericalla definitions: instruction layout, opcodes, fetch FSM states and sizing.
package jericalla_pkg;

  localparam int unsigned INSTR_WIDTH = 17;
  localparam int unsigned IMEM_DEPTH  = 32;
  localparam int unsigned ADDR_WIDTH  = $clog2(IMEM_DEPTH);
  localparam int unsigned FIFO_DEPTH  = 4;

  localparam int unsigned OPCODE_MSB = 16;
  localparam int unsigned OPCODE_LSB = 15;
  localparam int unsigned WR_MSB     = 14;
  localparam int unsigned WR_LSB     = 10;
  localparam int unsigned RDA_MSB    = 9;
  localparam int unsigned RDA_LSB    = 5;
  localparam int unsigned RDB_MSB    = 4;
  localparam int unsigned RDB_LSB    = 0;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_TERN = 2'b10,
    OP_SW   = 2'b11
  } opcode_e;

  typedef struct packed {
    opcode_e    opcode;
    logic [4:0] wr;
    logic [4:0] rda;
    logic [4:0] rdb;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } fetch_state_t;

endpackage

// File: rtl/jericalla_fetch_fifo.sv
// Synchronous prefetch FIFO with registered count/full/empty; clear drops all entries.
module jericalla_fetch_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;
  logic [CNT_W-1:0] count_nxt_c;

  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle
  always_comb begin
    do_pop_c    = pop && !empty;
    do_push_c   = push && (!full || do_pop_c);
    count_nxt_c = count;
    if (do_push_c && !do_pop_c) begin
      count_nxt_c = count + CNT_W'(1);
    end else if (!do_push_c && do_pop_c) begin
      count_nxt_c = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) begin
        store[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push_c) begin
        store[wr_ptr] <= din;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt_c;
      full  <= (count_nxt_c == CNT_W'(DEPTH));
      empty <= (count_nxt_c == '0);
    end
  end

  assign dout = store[rd_ptr];

endmodule

// File: rtl/jericalla_fetch_unit.sv
// Jericalla fetch stage: loadable imem, PC/FSM, prefetch FIFO with valid/ready output.
// JERICALLA_FETCH_LOOP_EN: wrap pc to start_addr after last_addr instead of draining.
module jericalla_fetch_unit
  import jericalla_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   load_we,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  start_addr,
  input  logic [ADDR_WIDTH-1:0]  last_addr,
  input  logic                   flush,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_t          state;
  instr_t                imem [IMEM_DEPTH];
  instr_t                rd_data;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] end_pc;
  logic                  one_word;
`ifdef JERICALLA_FETCH_LOOP_EN
  logic [ADDR_WIDTH-1:0] first_pc;
`endif
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  idle_like_c;
  logic                  issue_c;
  logic                  pop_c;
  logic                  last_issue_c;

  // Issue only when the FIFO can absorb every word already requested
  always_comb begin
    idle_like_c  = (state == IDLE) || (state == DONE);
    issue_c      = (state == FETCH) && !flush && !fifo_full &&
                   ((SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH));
    pop_c        = instr_valid && instr_ready && !flush;
    last_issue_c = (pc == end_pc) || one_word;
  end

  always_ff @(posedge clock) begin
    if (load_we && idle_like_c) begin
      imem[load_addr] <= instr_t'(load_data);
    end
    if (issue_c) begin
      rd_data <= imem[pc];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= '0;
      end_pc   <= '0;
      one_word <= 1'b0;
`ifdef JERICALLA_FETCH_LOOP_EN
      first_pc <= '0;
`endif
      inflight <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      inflight <= issue_c;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state    <= FETCH;
              pc       <= start_addr;
              end_pc   <= last_addr;
              one_word <= (start_addr > last_addr);
`ifdef JERICALLA_FETCH_LOOP_EN
              first_pc <= start_addr;
`endif
              busy     <= 1'b1;
              done     <= 1'b0;
            end
          end
          FETCH: begin
            if (issue_c) begin
              if (last_issue_c) begin
`ifdef JERICALLA_FETCH_LOOP_EN
                pc <= first_pc;
`else
                pc    <= pc + ADDR_WIDTH'(1);
                state <= DRAIN;
`endif
              end else begin
                pc <= pc + ADDR_WIDTH'(1);
              end
            end
          end
          DRAIN: begin
            if (!inflight && fifo_empty) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  jericalla_fetch_fifo #(
    .WIDTH (INSTR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (flush),
    .push    (inflight),
    .pop     (pop_c),
    .din     (rd_data),
    .dout    (instr_out),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign pc_out      = pc;

endmodule

// File: tb/tb_jericalla_fetch_unit.sv
// Self-checking bench for jericalla_fetch_unit: program-order reference model plus scenario tasks.
module tb_jericalla_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_we = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [16:0] load_data = '0;
  logic        start = 1'b0;
  logic [4:0]  start_addr = '0;
  logic [4:0]  last_addr = '0;
  logic        flush = 1'b0;
  logic [16:0] instr_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [4:0]  pc_out;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [16:0] model_mem [32];
  logic [16:0] exp_q [$];

  jericalla_fetch_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .start_addr  (start_addr),
    .last_addr   (last_addr),
    .flush       (flush),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_out      (pc_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: one pass delivers mem[s..l] in order, or only mem[s] when s > l
  task automatic model_program(input int s, input int l);
    exp_q.delete();
    if (s > l) exp_q.push_back(model_mem[s]);
    else for (int a = s; a <= l; a++) exp_q.push_back(model_mem[a]);
  endtask

  task automatic drive_load(input int a, input logic [16:0] d);
    load_we = 1'b1; load_addr = 5'(a); load_data = d;
    tick();
    load_we = 1'b0;
  endtask

  task automatic pulse_start(input int s, input int l);
    start = 1'b1; start_addr = 5'(s); last_addr = 5'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic load_all();
    logic [16:0] w;
    for (int a = 0; a < 32; a++) begin
      case (a)
        0: w = 17'h00001;
        1: w = 17'h08422;
        2: w = 17'h10C43;
        3: w = 17'h018E4;
        default: w = 17'($urandom);
      endcase
      model_mem[a] = w;
      drive_load(a, w);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", instr_valid); else n_pass++;
    n_checks++; if (instr_out !== 17'h0) $display("FAIL reset_instr got=%h exp=0", instr_out); else n_pass++;
    n_checks++; if (pc_out !== 5'd0) $display("FAIL reset_pc got=%0d exp=0", pc_out); else n_pass++;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); else n_pass++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int got = 0, first_c = -1, last_c = -1;
    model_program(0, 3);
    instr_ready = 1'b1;
    pulse_start(0, 3);
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy got=%b exp=1", busy); else n_pass++;
    tick();
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL basic_lat1_valid got=%b exp=0", instr_valid); else n_pass++;
    tick();
    n_checks++; if (instr_valid !== 1'b1) $display("FAIL basic_lat2_valid got=%b exp=1", instr_valid); else n_pass++;
    for (int c = 0; c < 40 && !done; c++) begin
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL basic_extra got=%h exp=none", instr_out);
        else if (instr_out !== exp_q[0]) $display("FAIL basic_word got=%h exp=%h", instr_out, exp_q[0]);
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (first_c < 0) first_c = c;
        last_c = c; got++;
      end
      tick();
    end
    n_checks++; if (got != 4) $display("FAIL basic_count got=%0d exp=4", got); else n_pass++;
    n_checks++; if (last_c - first_c != 3) $display("FAIL basic_throughput got=%0d exp=3", last_c - first_c); else n_pass++;
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL basic_done got=%b%b exp=01", busy, done); else n_pass++;
  endtask

  task automatic test_stall();
    int got = 0;
    model_program(0, 3);
    instr_ready = 1'b0;
    pulse_start(0, 3);
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (pc_out !== 5'd4) $display("FAIL stall_pc got=%0d exp=4", pc_out); else n_pass++;
    n_checks++; if (instr_valid !== 1'b1 || instr_out !== 17'h00001) $display("FAIL stall_head got=%b/%h exp=1/00001", instr_valid, instr_out); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL stall_busy got=%b exp=1", busy); else n_pass++;
    instr_ready = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL stall_extra got=%h exp=none", instr_out);
        else if (instr_out !== exp_q[0]) $display("FAIL stall_word got=%h exp=%h", instr_out, exp_q[0]);
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      tick();
    end
    n_checks++; if (got != 4 || done !== 1'b1) $display("FAIL stall_count got=%0d/%b exp=4/1", got, done); else n_pass++;
  endtask

  task automatic test_random_ready();
    for (int it = 0; it < 6; it++) begin
      int s = int'($urandom_range(0, 20));
      int len = int'($urandom_range(1, 10));
      int got = 0;
      logic hold = 1'b0;
      logic [16:0] hold_val = '0;
      model_program(s, s + len - 1);
      pulse_start(s, s + len - 1);
      for (int c = 0; c < 200 && !done; c++) begin
        instr_ready = (it == 0) ? 1'(c % 2) : 1'($urandom % 2);
        if (hold) begin
          n_checks++;
          if (instr_valid !== 1'b1 || instr_out !== hold_val) $display("FAIL rand_stable got=%b/%h exp=1/%h", instr_valid, instr_out, hold_val);
          else n_pass++;
        end
        hold = instr_valid && !instr_ready;
        hold_val = instr_out;
        if (instr_valid && instr_ready) begin
          n_checks++;
          if (exp_q.size() == 0) $display("FAIL rand_extra got=%h exp=none", instr_out);
          else if (instr_out !== exp_q[0]) $display("FAIL rand_word got=%h exp=%h", instr_out, exp_q[0]);
          else n_pass++;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          got++;
        end
        tick();
      end
      n_checks++; if (got != len || done !== 1'b1) $display("FAIL rand_count got=%0d/%b exp=%0d/1", got, done, len); else n_pass++;
    end
    instr_ready = 1'b1;
  endtask

  task automatic test_flush();
    int got = 0;
    instr_ready = 1'b0;
    pulse_start(0, 7);
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL flush_valid got=%b exp=0", instr_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL flush_idle got=%b%b exp=00", busy, done); else n_pass++;
    tick(); tick(); tick();
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL flush_dropped got=%b exp=0", instr_valid); else n_pass++;
    model_program(2, 3);
    instr_ready = 1'b1;
    pulse_start(2, 3);
    for (int c = 0; c < 40 && !done; c++) begin
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL flush_extra got=%h exp=none", instr_out);
        else if (instr_out !== exp_q[0]) $display("FAIL flush_restart_word got=%h exp=%h", instr_out, exp_q[0]);
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      tick();
    end
    n_checks++; if (got != 2 || done !== 1'b1) $display("FAIL flush_restart_count got=%0d/%b exp=2/1", got, done); else n_pass++;
  endtask

  task automatic test_async_reset();
    int got = 0;
    instr_ready = 1'b0;
    pulse_start(0, 3);
    for (int i = 0; i < 6; i++) tick();
    n_checks++; if (busy !== 1'b1 || pc_out !== 5'd4) $display("FAIL areset_pre got=%b/%0d exp=1/4", busy, pc_out); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (instr_valid !== 1'b0 || instr_out !== 17'h0) $display("FAIL areset_out got=%b/%h exp=0/0", instr_valid, instr_out); else n_pass++;
    n_checks++; if (pc_out !== 5'd0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL areset_state got=%0d/%b%b exp=0/00", pc_out, busy, done); else n_pass++;
    tick();
    reset_n = 1'b1;
    tick();
    model_program(0, 3);
    instr_ready = 1'b1;
    pulse_start(0, 3);
    for (int c = 0; c < 40 && !done; c++) begin
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL areset_extra got=%h exp=none", instr_out);
        else if (instr_out !== exp_q[0]) $display("FAIL areset_replay_word got=%h exp=%h", instr_out, exp_q[0]);
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      tick();
    end
    n_checks++; if (got != 4 || done !== 1'b1) $display("FAIL areset_replay_count got=%0d/%b exp=4/1", got, done); else n_pass++;
  endtask

  task automatic test_single_and_load();
    int got = 0;
    // start_addr above last_addr fetches exactly one word
    model_program(5, 2);
    instr_ready = 1'b1;
    pulse_start(5, 2);
    for (int c = 0; c < 40 && !done; c++) begin
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (instr_out !== model_mem[5]) $display("FAIL single_word got=%h exp=%h", instr_out, model_mem[5]); else n_pass++;
        got++;
      end
      tick();
    end
    n_checks++; if (got != 1 || done !== 1'b1) $display("FAIL single_count got=%0d/%b exp=1/1", got, done); else n_pass++;
    // load during FETCH is ignored; model memory left untouched
    got = 0;
    model_program(0, 9);
    instr_ready = 1'b0;
    pulse_start(0, 9);
    drive_load(8, ~model_mem[8]);
    instr_ready = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL load_ign_extra got=%h exp=none", instr_out);
        else if (instr_out !== exp_q[0]) $display("FAIL load_ign_word got=%h exp=%h", instr_out, exp_q[0]);
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      tick();
    end
    n_checks++; if (got != 10 || done !== 1'b1) $display("FAIL load_ign_count got=%0d/%b exp=10/1", got, done); else n_pass++;
    // load in DONE is honoured
    model_mem[8] = 17'h1ABCD;
    drive_load(8, 17'h1ABCD);
    pulse_start(8, 8);
    got = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (instr_out !== model_mem[8]) $display("FAIL load_done_word got=%h exp=%h", instr_out, model_mem[8]); else n_pass++;
        got++;
      end
      tick();
    end
    n_checks++; if (got != 1) $display("FAIL load_done_count got=%0d exp=1", got); else n_pass++;
  endtask

  task automatic test_wrap();
    int got = 0;
    instr_ready = 1'b1;
    pulse_start(0, 1);
`ifdef JERICALLA_FETCH_LOOP_EN
    for (int c = 0; c < 40 && got < 10; c++) begin
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (instr_out !== model_mem[got % 2]) $display("FAIL loop_word got=%h exp=%h", instr_out, model_mem[got % 2]); else n_pass++;
        got++;
      end
      tick();
    end
    n_checks++; if (got != 10 || done !== 1'b0 || busy !== 1'b1) $display("FAIL loop_state got=%0d/%b%b exp=10/10", got, busy, done); else n_pass++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (instr_valid !== 1'b0 || busy !== 1'b0) $display("FAIL loop_flush got=%b/%b exp=0/0", instr_valid, busy); else n_pass++;
`else
    model_program(0, 1);
    for (int c = 0; c < 40 && !done; c++) begin
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL wrap_extra got=%h exp=none", instr_out);
        else if (instr_out !== exp_q[0]) $display("FAIL wrap_word got=%h exp=%h", instr_out, exp_q[0]);
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      tick();
    end
    n_checks++; if (got != 2 || done !== 1'b1) $display("FAIL wrap_count got=%0d/%b exp=2/1", got, done); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    load_all();
`ifndef JERICALLA_FETCH_LOOP_EN
    test_basic();
    test_stall();
    test_random_ready();
    test_flush();
    test_async_reset();
    test_single_and_load();
`endif
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
